axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream output between NUM_IN requesting streams. It sequences the shared datapath in front of downstream consumers (DAC/readout stream paths), holding each grant until a packet ends or a beat limit expires. It then passes ownership to the next requester in rotation and exports the current grant for status and debug.

## Interface
- NUM_IN, 4: number of input streams, 2..16.
- WIDTH, 16: tdata width in bits.
- MAX_BEATS, 256: maximum accepted beats per grant, ≥1; forces release on streams without tlast.
- IDX_W, $clog2(NUM_IN): derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_IN  per-input valid; bit i belongs to input i.
- s_axis_tready  out  NUM_IN  per-input ready.
- s_axis_tdata  in  NUM_IN*WIDTH  input i occupies bits [i*WIDTH +: WIDTH].
- s_axis_tlast  in  NUM_IN  per-input end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  WIDTH  output data.
- m_axis_tlast  out  1  output last. Asserted on the tlast beat and on the forced MAX_BEATS release beat.
- grant_idx  out  IDX_W  index of the current or most recent grant.
- grant_active  out  1  high while in GRANT.

## Operation
- There are two states, IDLE and GRANT. Registers: state, ptr (IDX_W), grant_idx, beat_cnt ($clog2(MAX_BEATS+1) bits).
- IDLE:
  - Search s_axis_tvalid starting at ptr, ascending with wrap. The first set bit wins.
  - If a winner exists: grant_idx ← winner, beat_cnt ← 0, go to GRANT.
  - If no input is valid, stay in IDLE.
  - In IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and all s_axis_tready=0.
- GRANT:
  - Combinational pass-through of input grant_idx: m_axis_tvalid/tdata/tlast follow that input.
  - s_axis_tready[grant_idx] = m_axis_tready. All other readies are 0.
  - A handshake is m_axis_tvalid & m_axis_tready. Each handshake increments beat_cnt.
  - Release occurs on a handshake where the granted tlast=1 or beat_cnt == MAX_BEATS-1. On release: ptr ← (grant_idx+1) mod NUM_IN, go to IDLE.
  - On a forced release, m_axis_tlast is driven 1 on that beat regardless of input tlast.
  - Granted tvalid dropping mid-packet does not release the grant; the arbiter waits.
- ptr wraps from NUM_IN-1 to 0. When NUM_IN is not a power of two, ptr never takes values ≥ NUM_IN.
- Simultaneous requests: the nearest index at or after ptr wins. A just-released input gets lowest priority for the next decision.
- No data is buffered; the block adds no storage on the data path.

## Timing
- Reset values: state=IDLE, ptr=0, grant_idx=0, beat_cnt=0, grant_active=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=all 0.
- Arbitration latency: the first beat of a packet can be accepted no earlier than 1 cycle after its tvalid is sampled in IDLE.
- Packets are separated by exactly one IDLE bubble cycle. Sustained throughput is P/(P+1) for P-beat packets.
- Data path latency is 0 cycles (combinational) while in GRANT.
- Reset asserted mid-packet: the grant is dropped at the next edge and the packet is truncated downstream without tlast. This is accepted behaviour; upstream must also be reset.
- grant_idx and grant_active are registered and change on the edge that enters or leaves GRANT.

## Structure
- Package axis_arb_pkg holds:
  - the state enum (ST_IDLE, ST_GRANT);
  - a function that computes IDX_W from NUM_IN.
- Sub-module rr_priority_select: purely combinational.
  - Inputs: req[NUM_IN], ptr[IDX_W].
  - Outputs: found, idx[IDX_W].
  - Implemented as a double-width rotate-and-priority-encode. It is instantiated once and is unit-testable on its own.

## Test plan
All scenarios use NUM_IN=4 and MAX_BEATS=8.
1. **Reset:** hold reset 3 cycles with all tvalid=1 → all outputs at reset values. First grant_idx=0 appears on the cycle after release.
2. **Fairness:** all four inputs continuously valid, each sending 2-beat packets, tready=1 → grant order 0,1,2,3,0. One bubble between packets, 12 cycles per rotation.
3. **Wrap priority:** ptr=3 (after serving input 2), only inputs 1 and 3 valid → input 3 granted, then input 1.
4. **Forced release:** input 0 streams 20 beats with no tlast → release after 8 handshakes with m_axis_tlast=1 on beat 8. Next grant goes to a valid input ≥1; input 0 regains the grant when it is alone.
5. **Backpressure:** toggle tready 1,0,0,1 during a 4-beat packet on input 2 → exactly 4 handshakes in order and no data duplicated. s_axis_tready[0,1,3] stay 0 throughout.
6. **Reset mid-packet:** assert reset after beat 2 of 5 → next cycle m_axis_tvalid=0 and all readies 0. Arbitration restarts at input 0.

Source files
------------

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the packet-granular AXI-Stream round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding
//   calc_idx_w  : width of an input index for a given input count
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width for NUM_IN inputs; never less than one bit.
    function automatic int calc_idx_w(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for the round-robin arbiter: NUM_IN slave streams in,
// one master stream out.
//   s_axis_tvalid/tready/tlast : per-input handshake, bit i = input i
//   s_axis_tdata               : input i at [i*WIDTH +: WIDTH]
//   m_axis_*                   : shared output stream
// Modports:
//   master : the arbiter view (drives readies and the output stream)
//   slave  : the environment view (drives inputs and m_axis_tready)
interface axis_rr_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 16
);
    logic [NUM_IN-1:0]       s_axis_tvalid;
    logic [NUM_IN-1:0]       s_axis_tready;
    logic [NUM_IN*WIDTH-1:0] s_axis_tdata;
    logic [NUM_IN-1:0]       s_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [WIDTH-1:0]        m_axis_tdata;
    logic                    m_axis_tlast;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/axis_rr_arbiter_rr_priority_select.sv
// Combinational round-robin priority select.
//   req   : request vector, bit i = input i
//   ptr   : index with highest priority this decision
//   found : at least one request is set
//   idx   : first set request at or after ptr, ascending with wrap
// The request vector is doubled and shifted right by ptr so the search always
// starts at bit 0; the winning offset is then added back to ptr modulo NUM_IN.
module rr_priority_select
    import axis_arb_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int IDX_W  = calc_idx_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic [2*NUM_IN-1:0] dbl;
    logic [NUM_IN-1:0]   rot;
    logic [IDX_W:0]      off;
    logic [IDX_W:0]      sum;

    assign dbl   = {req, req} >> ptr;
    assign rot   = dbl[NUM_IN-1:0];
    assign found = |rot;

    always_comb begin
        off = '0;
        // Descending scan so the lowest set bit is the final assignment.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot[k]) off = (IDX_W + 1)'(k);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDX_W + 1)'(NUM_IN)) sum = sum - (IDX_W + 1)'(NUM_IN);
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output between
// NUM_IN inputs. A grant is held until the granted input's tlast beat is
// accepted or MAX_BEATS beats have been accepted, then priority moves to the
// input after the one just served. The data path is pure combinational muxing.
//   clk, reset   : single clock, synchronous active-high reset
//   bus          : axis_rr_arbiter_if master view (inputs and shared output)
//   grant_idx    : current or most recent granted input
//   grant_active : high while a grant is held
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_IN    = 4,
    parameter  int WIDTH     = 16,
    parameter  int MAX_BEATS = 256,
    localparam int IDX_W     = calc_idx_w(NUM_IN)
) (
    input  logic                 clk,
    input  logic                 reset,
    axis_rr_arbiter_if.master    bus,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_active
);

    localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    arb_state_e                   state;
    logic [IDX_W-1:0]             ptr;
    logic [CNT_W-1:0]             beat_cnt;

    logic                         found;
    logic [IDX_W-1:0]             win_idx;
    logic [NUM_IN-1:0][WIDTH-1:0] s_data;
    logic                         g_valid;
    logic                         g_last;
    logic                         at_limit;
    logic                         hs;

    rr_priority_select #(.NUM_IN(NUM_IN)) u_sel (
        .req   (bus.s_axis_tvalid),
        .ptr   (ptr),
        .found (found),
        .idx   (win_idx)
    );

    assign s_data   = bus.s_axis_tdata;
    assign g_valid  = bus.s_axis_tvalid[grant_idx];
    assign g_last   = bus.s_axis_tlast[grant_idx];
    assign at_limit = (beat_cnt == LAST_CNT);
    assign hs       = (state == ST_GRANT) && g_valid && bus.m_axis_tready;

    // Output mux: everything quiet outside GRANT. The beat-limit release is
    // marked as end of packet so downstream framing stays consistent.
    always_comb begin
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.s_axis_tready = '0;
        if (state == ST_GRANT) begin
            bus.m_axis_tvalid            = g_valid;
            bus.m_axis_tdata             = s_data[grant_idx];
            bus.m_axis_tlast             = g_last || at_limit;
            bus.s_axis_tready[grant_idx] = bus.m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            grant_idx    <= '0;
            beat_cnt     <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_idx    <= win_idx;
                        beat_cnt     <= '0;
                        state        <= ST_GRANT;
                        grant_active <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // A stalled granted input keeps the grant; only an
                    // accepted beat can end it.
                    if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (g_last || at_limit) begin
                            ptr          <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                            state        <= ST_IDLE;
                            grant_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
